rmst_fm_tile_ctrl: RTL

Parametrised read-master controller that streams a 3-D feature-map tile (channels x rows x cols) from external memory into an on-chip load FIFO. It generalises the fixed-size output-FM loader:
- tile sizes are runtime inputs;
- each row segment is split into bursts of at most MAX_BURST words;
- flow control uses the FIFO free-space count, not an almost-full flag.

It sits between the tile scheduler (load_start/load_done) and the Avalon read master (load_trans_start/load_trans_done).

---
 rtl/rmst_fm_tile_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/rmst_fm_tile_ctrl.sv
// Read-master controller: streams a channels x rows x cols feature-map tile into the load FIFO as bursts.
// Optional: define RMST_EDGE_CLIP_EN to clip latched tile sizes to the feature-map boundary.
module rmst_fm_tile_ctrl #(
  parameter int AW        = 12,
  parameter int CW        = 16,
  parameter int DW        = 32,
  parameter int R         = 64,
  parameter int C         = 32,
  parameter int FM_BASE   = 0,
  parameter int MAX_BURST = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  input  logic [CW-1:0] tile_base_n,
  input  logic [CW-1:0] tile_base_row,
  input  logic [CW-1:0] tile_base_col,
  input  logic [CW-1:0] tile_tn,
  input  logic [CW-1:0] tile_tr,
  input  logic [CW-1:0] tile_tc,
  input  logic [AW:0]   fifo_space,
  output logic          load_trans_start,
  output logic [DW-1:0] param_raddr,
  output logic [AW-1:0] param_iolen,
  input  logic          load_trans_done,
  output logic          load_done,
  output logic          busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_WAIT,
    S_ISSUE,
    S_TRANS,
    S_DONE
  } state_e;

  localparam logic [DW-1:0] RC_DW   = DW'(R * C);
  localparam logic [DW-1:0] C_DW    = DW'(C);
  localparam logic [DW-1:0] BASE_DW = DW'(FM_BASE);
  localparam logic [CW-1:0] MB_CW   = CW'(MAX_BURST);
  localparam logic [AW-1:0] MB_AW   = AW'(MAX_BURST);

  state_e        state_q;
  logic [CW-1:0] bn_q, br_q, bc_q;
  logic [CW-1:0] tn_q, tr_q, tc_q;
  logic [CW-1:0] n_q, r_q, col_q;
  logic          lts_q, load_done_q, busy_q;
  logic [DW-1:0] raddr_q;
  logic [AW-1:0] iolen_q;

  logic [CW-1:0] tr_d, tc_d;
  logic [CW-1:0] rem_d;
  logic [AW-1:0] len_d;
  logic [DW-1:0] word_d, raddr_d;
  logic [CW-1:0] col_sum_d, r_inc_d, n_inc_d;
  logic          col_wrap_d, row_wrap_d, tile_end_d, zero_size_d;

`ifdef RMST_EDGE_CLIP_EN
  localparam logic [CW-1:0] R_CW = CW'(R);
  localparam logic [CW-1:0] C_CW = CW'(C);
  logic [CW-1:0] row_room_d, col_room_d;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    tr_d = tile_tr;
    tc_d = tile_tc;
`ifdef RMST_EDGE_CLIP_EN
    row_room_d = R_CW - tile_base_row;
    col_room_d = C_CW - tile_base_col;
    if (tile_base_row >= R_CW)    tr_d = '0;
    else if (tile_tr > row_room_d) tr_d = row_room_d;
    if (tile_base_col >= C_CW)    tc_d = '0;
    else if (tile_tc > col_room_d) tc_d = col_room_d;
`endif

    rem_d = tc_q - col_q;
    len_d = (rem_d < MB_CW) ? rem_d[AW-1:0] : MB_AW;

    // Modulo-2^DW arithmetic throughout equals full-width compute followed by truncation.
    word_d = BASE_DW
           + (DW'(bn_q) + DW'(n_q)) * RC_DW
           + (DW'(br_q) + DW'(r_q)) * C_DW
           + DW'(bc_q) + DW'(col_q);
    raddr_d = {word_d[DW-3:0], 2'b00};

    col_sum_d   = col_q + CW'(iolen_q);
    r_inc_d     = r_q + CW'(1);
    n_inc_d     = n_q + CW'(1);
    col_wrap_d  = (col_sum_d == tc_q);
    row_wrap_d  = col_wrap_d && (r_inc_d == tr_q);
    tile_end_d  = row_wrap_d && (n_inc_d == tn_q);
    zero_size_d = (tn_q == '0) || (tr_q == '0) || (tc_q == '0);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bn_q        <= '0;
      br_q        <= '0;
      bc_q        <= '0;
      tn_q        <= '0;
      tr_q        <= '0;
      tc_q        <= '0;
      n_q         <= '0;
      r_q         <= '0;
      col_q       <= '0;
      lts_q       <= 1'b0;
      load_done_q <= 1'b0;
      busy_q      <= 1'b0;
      raddr_q     <= '0;
      iolen_q     <= '0;
    end else begin
      lts_q       <= 1'b0;
      load_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (load_start) begin
            bn_q    <= tile_base_n;
            br_q    <= tile_base_row;
            bc_q    <= tile_base_col;
            tn_q    <= tile_tn;
            tr_q    <= tr_d;
            tc_q    <= tc_d;
            n_q     <= '0;
            r_q     <= '0;
            col_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          // Empty tiles are detected on the latched (possibly clipped) sizes, giving load_done 2 cycles after load_start.
          if (zero_size_d) begin
            load_done_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_DONE;
          end else begin
            raddr_q <= raddr_d;
            iolen_q <= len_d;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (fifo_space >= {1'b0, iolen_q}) begin
            lts_q   <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: state_q <= S_TRANS;
        S_TRANS: begin
          if (load_trans_done) begin
            if (col_wrap_d) begin
              col_q <= '0;
              if (row_wrap_d) begin
                r_q <= '0;
                n_q <= n_inc_d;
              end else begin
                r_q <= r_inc_d;
              end
            end else begin
              col_q <= col_sum_d;
            end
            if (tile_end_d) begin
              load_done_q <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= S_DONE;
            end else begin
              state_q <= S_CALC;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign load_trans_start = lts_q;
  assign param_raddr      = raddr_q;
  assign param_iolen      = iolen_q;
  assign load_done        = load_done_q;
  assign busy             = busy_q;

endmodule
